// File: rtl/alu_issue_seq.sv
// Issue/writeback sequencer in front of a clocked ALU. Each instruction runs
// IDLE -> ISSUE -> WB with operands read at accept and the result written back at the WB edge.
module alu_issue_seq #(
   parameter int DATA_W = 8,
   parameter int REG_AW = 2,
   parameter int OPC_W  = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [OPC_W+3*REG_AW+DATA_W+1:0] in_instr,
   output logic [DATA_W-1:0]             alu_a,
   output logic [DATA_W-1:0]             alu_b,
   output logic [OPC_W-1:0]              alu_opcode,
   input  logic [DATA_W-1:0]             alu_op,
   input  logic                          alu_carry,
   input  logic                          alu_zero,
   output logic                          done,
   output logic [DATA_W-1:0]             result,
   output logic                          carry_flag,
   output logic                          zero_flag,
   input  logic [REG_AW-1:0]             dbg_sel,
   output logic [DATA_W-1:0]             dbg_data
);
   localparam int NREG    = 2 ** REG_AW;
   localparam int WB_BIT  = DATA_W;
   localparam int IMM_BIT = DATA_W + 1;
   localparam int RSB_LSB = DATA_W + 2;
   localparam int RSA_LSB = RSB_LSB + REG_AW;
   localparam int RD_LSB  = RSA_LSB + REG_AW;
   localparam int OPC_LSB = RD_LSB + REG_AW;

   typedef enum logic [1:0] {IDLE, ISSUE, WB} state_t;

   state_t                        state_q, state_d;
   logic [NREG-1:0][DATA_W-1:0]   rf_q, rf_d;
   logic [DATA_W-1:0]             alu_a_q, alu_a_d, alu_b_q, alu_b_d;
   logic [OPC_W-1:0]              opc_q, opc_d;
   logic [REG_AW-1:0]             rd_q, rd_d;
   logic                          wb_en_q, wb_en_d;
   logic                          done_q, done_d;
   logic [DATA_W-1:0]             result_q, result_d;
   logic                          carry_q, carry_d, zero_q, zero_d;

   logic [OPC_W-1:0]              f_opc;
   logic [REG_AW-1:0]             f_rd, f_rsa, f_rsb;
   logic                          f_imm_sel, f_wb_en;
   logic [DATA_W-1:0]             f_imm;

   assign f_opc     = in_instr[OPC_LSB +: OPC_W];
   assign f_rd      = in_instr[RD_LSB  +: REG_AW];
   assign f_rsa     = in_instr[RSA_LSB +: REG_AW];
   assign f_rsb     = in_instr[RSB_LSB +: REG_AW];
   assign f_imm_sel = in_instr[IMM_BIT];
   assign f_wb_en   = in_instr[WB_BIT];
   assign f_imm     = in_instr[DATA_W-1:0];

   always_comb begin
      state_d  = state_q;
      rf_d     = rf_q;
      alu_a_d  = alu_a_q;
      alu_b_d  = alu_b_q;
      opc_d    = opc_q;
      rd_d     = rd_q;
      wb_en_d  = wb_en_q;
      done_d   = 1'b0;
      result_d = result_q;
      carry_d  = carry_q;
      zero_d   = zero_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               alu_a_d = rf_q[f_rsa];
               alu_b_d = f_imm_sel ? f_imm : rf_q[f_rsb];
               opc_d   = f_opc;
               rd_d    = f_rd;
               wb_en_d = f_wb_en;
               state_d = ISSUE;
            end
         end
         ISSUE: state_d = WB;
         WB: begin
            // alu_op holds the result the ALU registered at the end of ISSUE
            if (wb_en_q) rf_d[rd_q] = alu_op;
            result_d = alu_op;
            carry_d  = alu_carry;
            zero_d   = alu_zero;
            done_d   = 1'b1;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         rf_q     <= '0;
         alu_a_q  <= '0;
         alu_b_q  <= '0;
         opc_q    <= '0;
         rd_q     <= '0;
         wb_en_q  <= 1'b0;
         done_q   <= 1'b0;
         result_q <= '0;
         carry_q  <= 1'b0;
         zero_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         rf_q     <= rf_d;
         alu_a_q  <= alu_a_d;
         alu_b_q  <= alu_b_d;
         opc_q    <= opc_d;
         rd_q     <= rd_d;
         wb_en_q  <= wb_en_d;
         done_q   <= done_d;
         result_q <= result_d;
         carry_q  <= carry_d;
         zero_q   <= zero_d;
      end
   end

   assign in_ready   = (state_q == IDLE);
   assign alu_a      = alu_a_q;
   assign alu_b      = alu_b_q;
   assign alu_opcode = opc_q;
   assign done       = done_q;
   assign result     = result_q;
   assign carry_flag = carry_q;
   assign zero_flag  = zero_q;
   assign dbg_data   = rf_q[dbg_sel];
endmodule

// File: tb/tb_alu_issue_seq.sv
// Directed bench for alu_issue_seq driving a behavioural clocked ALU (0: a+b, 1: a-b).
module tb_alu_issue_seq;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [19:0] in_instr;
   logic [7:0]  alu_a, alu_b, alu_op;
   logic [3:0]  alu_opcode;
   logic        alu_carry, alu_zero;
   logic        done, carry_flag, zero_flag;
   logic [7:0]  result, dbg_data;
   logic [1:0]  dbg_sel;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   alu_issue_seq dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_instr(in_instr), .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
      .alu_op(alu_op), .alu_carry(alu_carry), .alu_zero(alu_zero), .done(done),
      .result(result), .carry_flag(carry_flag), .zero_flag(zero_flag),
      .dbg_sel(dbg_sel), .dbg_data(dbg_data)
   );

   always @(posedge clk) begin
      case (alu_opcode)
         4'h0:    {alu_carry, alu_op} <= {1'b0, alu_a} + {1'b0, alu_b};
         4'h1:    {alu_carry, alu_op} <= {1'b0, alu_a} - {1'b0, alu_b};
         default: {alu_carry, alu_op} <= 9'h000;
      endcase
   end
   assign alu_zero = (alu_op == 8'h00);

   function automatic logic [19:0] mk(input logic [3:0] opc, input logic [1:0] rd,
         input logic [1:0] rsa, input logic [1:0] rsb, input logic imm_sel,
         input logic wb, input logic [7:0] imm);
      return {opc, rd, rsa, rsb, imm_sel, wb, imm};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic dbg_chk(input string nm, input logic [1:0] sel, input logic [7:0] exp);
      dbg_sel = sel;
      #1;
      chk(nm, {24'h0, dbg_data}, {24'h0, exp});
   endtask

   // Drive one instruction at a negedge; done must appear exactly at the third edge counted from accept.
   task automatic issue(input logic [19:0] ins, input string nm);
      @(negedge clk);
      in_instr = ins;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_instr = 20'hFFFFF;
      chk({nm, " ready_in_issue"}, {31'h0, in_ready}, 32'h0);
      chk({nm, " done_in_issue"}, {31'h0, done}, 32'h0);
      @(posedge clk); #1;
      chk({nm, " done_in_wb"}, {31'h0, done}, 32'h0);
      @(posedge clk); #1;
      chk({nm, " done_pulse"}, {31'h0, done}, 32'h1);
      chk({nm, " ready_after"}, {31'h0, in_ready}, 32'h1);
   endtask

   typedef struct {
      logic [19:0] instr;
      logic [7:0]  res;
      logic        c;
      logic        z;
      logic [1:0]  sel;
      logic [7:0]  dbg;
   } vec_t;

   vec_t vt[$];
   logic [7:0] exp_b2b [4];

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; dbg_sel = '0;
      //          instr                                 res    c     z     sel    dbg
      vt.push_back('{mk(4'h0,2'd1,2'd0,2'd0,1,1,8'h0A), 8'h0A, 1'b0, 1'b0, 2'd1, 8'h0A});
      vt.push_back('{mk(4'h0,2'd2,2'd0,2'd0,1,1,8'h02), 8'h02, 1'b0, 1'b0, 2'd2, 8'h02});
      vt.push_back('{mk(4'h0,2'd3,2'd1,2'd2,0,1,8'h00), 8'h0C, 1'b0, 1'b0, 2'd3, 8'h0C});
      vt.push_back('{mk(4'h0,2'd1,2'd0,2'd0,1,1,8'hF6), 8'hF6, 1'b0, 1'b0, 2'd1, 8'hF6});
      vt.push_back('{mk(4'h0,2'd2,2'd0,2'd0,1,1,8'h0A), 8'h0A, 1'b0, 1'b0, 2'd2, 8'h0A});
      vt.push_back('{mk(4'h0,2'd3,2'd1,2'd2,0,1,8'h00), 8'h00, 1'b1, 1'b1, 2'd3, 8'h00});
      vt.push_back('{mk(4'h0,2'd1,2'd0,2'd0,1,1,8'h05), 8'h05, 1'b0, 1'b0, 2'd1, 8'h05});
      vt.push_back('{mk(4'h0,2'd2,2'd0,2'd0,1,1,8'h05), 8'h05, 1'b0, 1'b0, 2'd2, 8'h05});
      vt.push_back('{mk(4'h0,2'd3,2'd0,2'd0,1,1,8'h77), 8'h77, 1'b0, 1'b0, 2'd3, 8'h77});
      // sub without writeback: flags/result update, r3 keeps 77
      vt.push_back('{mk(4'h1,2'd3,2'd1,2'd2,0,0,8'h00), 8'h00, 1'b0, 1'b1, 2'd3, 8'h77});
      vt.push_back('{mk(4'h0,2'd1,2'd0,2'd0,1,1,8'hFE), 8'hFE, 1'b0, 1'b0, 2'd1, 8'hFE});
      exp_b2b = '{8'hFF, 8'h00, 8'h01, 8'h02};

      repeat (2) @(posedge clk);
      @(negedge clk); rst_n = 1'b1;
      #1;
      chk("rst in_ready", {31'h0, in_ready}, 32'h1);
      chk("rst done", {31'h0, done}, 32'h0);
      chk("rst flags", {30'h0, carry_flag, zero_flag}, 32'h0);
      chk("rst result", {24'h0, result}, 32'h0);
      for (int s = 0; s < 4; s++) dbg_chk($sformatf("rst dbg r%0d", s), 2'(s), 8'h00);

      for (int i = 0; i < vt.size(); i++) begin
         issue(vt[i].instr, $sformatf("vec%0d", i));
         chk($sformatf("vec%0d result", i), {24'h0, result}, {24'h0, vt[i].res});
         chk($sformatf("vec%0d carry", i), {31'h0, carry_flag}, {31'h0, vt[i].c});
         chk($sformatf("vec%0d zero", i), {31'h0, zero_flag}, {31'h0, vt[i].z});
         dbg_chk($sformatf("vec%0d dbg", i), vt[i].sel, vt[i].dbg);
      end
      dbg_chk("wb0 r1 kept", 2'd1, 8'hFE);
      dbg_chk("wb0 r2 kept", 2'd2, 8'h05);

      // dependent r1=r1+1 with in_valid held: accepts land 3 clocks apart
      @(negedge clk);
      in_instr = mk(4'h0, 2'd1, 2'd1, 2'd0, 1, 1, 8'h01);
      in_valid = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); #1;
         chk($sformatf("b2b%0d ready_issue", k), {31'h0, in_ready}, 32'h0);
         @(posedge clk); #1;
         chk($sformatf("b2b%0d ready_wb", k), {31'h0, in_ready}, 32'h0);
         @(posedge clk); #1;
         chk($sformatf("b2b%0d done", k), {31'h0, done}, 32'h1);
         chk($sformatf("b2b%0d result", k), {24'h0, result}, {24'h0, exp_b2b[k]});
         chk($sformatf("b2b%0d ready_idle", k), {31'h0, in_ready}, 32'h1);
         if (k == 1) chk("b2b wrap flags", {30'h0, carry_flag, zero_flag}, 32'h3);
         if (k == 3) begin
            @(negedge clk);
            in_valid = 1'b0;
         end
      end
      @(posedge clk); #1;
      chk("b2b no extra accept", {31'h0, in_ready}, 32'h1);
      dbg_chk("b2b r1 final", 2'd1, 8'h02);

      // reset in ISSUE discards the add into r2
      @(negedge clk);
      in_instr = mk(4'h0, 2'd2, 2'd0, 2'd0, 1, 1, 8'h33);
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("mid in_issue", {31'h0, in_ready}, 32'h0);
      @(negedge clk); rst_n = 1'b0;
      #1;
      chk("mid rst ready", {31'h0, in_ready}, 32'h1);
      for (int c = 0; c < 2; c++) begin
         @(posedge clk); #1;
         chk($sformatf("mid rst done%0d", c), {31'h0, done}, 32'h0);
      end
      @(negedge clk); rst_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(posedge clk); #1;
         chk($sformatf("mid post done%0d", c), {31'h0, done}, 32'h0);
      end
      chk("mid post ready", {31'h0, in_ready}, 32'h1);
      chk("mid post flags", {30'h0, carry_flag, zero_flag}, 32'h0);
      dbg_chk("mid r2 cleared", 2'd2, 8'h00);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
